// File: rtl/mpm_pg_alloc_arb.sv
// Round-robin arbiter multiplexing MPM write-port page requests onto one page allocator.
// Optional statistics counters are built when MPM_PG_ALLOC_ARB_STATS_EN is defined.
module mpm_pg_alloc_arb #(
    parameter int g_num_ports          = 7,
    parameter int g_page_address_width = 10,
    parameter int g_retry_delay        = 16
) (
    input  logic                                              clk_core_i,
    input  logic                                              rst_n_i,
    input  logic [g_num_ports-1:0]                            wp_pg_req_i,
    output logic [g_num_ports*g_page_address_width-1:0]       wp_pgaddr_o,
    output logic [g_num_ports-1:0]                            wp_pgaddr_valid_o,
    output logic                                              alloc_req_o,
    input  logic                                              alloc_done_i,
    input  logic [g_page_address_width-1:0]                   alloc_pgaddr_i,
    input  logic                                              alloc_nomem_i,
`ifdef MPM_PG_ALLOC_ARB_STATS_EN
    input  logic                                              stats_clr_i,
    output logic [31:0]                                       grant_cnt_o,
    output logic [31:0]                                       nomem_cnt_o,
    output logic [15:0]                                       max_wait_o,
`endif
    output logic                                              busy_o
);
    localparam int N  = g_num_ports;
    localparam int W  = g_page_address_width;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(g_retry_delay + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_WAIT} state_t;

    state_t              state_q;
    logic [N-1:0]        pend_q, pend_d, clr_vec;
    logic [PW-1:0]       rr_q, cur_q, win_idx;
    logic                win_vld;
    logic [CW-1:0]       cnt_q;
    logic [N-1:0][W-1:0] addr_q;
    logic [N-1:0]        valid_q;
    logic                req_q;
    logic                serve, nomem_ev;

    assign serve    = (state_q == S_REQ) && alloc_done_i && !alloc_nomem_i;
    assign nomem_ev = (state_q == S_REQ) && alloc_done_i && alloc_nomem_i;

    // A request arriving in the service cycle wins over the clear.
    always_comb begin
        clr_vec = '0;
        if (serve) clr_vec[cur_q] = 1'b1;
        pend_d = (pend_q & ~clr_vec) | wp_pg_req_i;
    end

    always_comb begin
        int p;
        win_vld = 1'b0;
        win_idx = '0;
        p       = 0;
        for (int k = 0; k < N; k++) begin
            p = int'(rr_q) + k;
            if (p >= N) p = p - N;
            if (!win_vld && pend_q[PW'(p)]) begin
                win_vld = 1'b1;
                win_idx = PW'(p);
            end
        end
    end

    always_ff @(posedge clk_core_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            rr_q    <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= '0;
            req_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= '0;
            case (state_q)
                S_IDLE: if (win_vld) begin
                    cur_q   <= win_idx;
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end
                S_REQ: if (alloc_done_i) begin
                    req_q <= 1'b0;
                    if (alloc_nomem_i) begin
                        cnt_q   <= CW'(g_retry_delay - 1);
                        state_q <= S_WAIT;
                    end else begin
                        addr_q[cur_q]  <= alloc_pgaddr_i;
                        valid_q[cur_q] <= 1'b1;
                        rr_q           <= (cur_q == PW'(N - 1)) ? '0 : cur_q + PW'(1);
                        state_q        <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                // Retry keeps cur_q: a starved port does not lose its turn.
                S_WAIT: if (cnt_q == '0) begin
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wp_pgaddr_o       = addr_q;
    assign wp_pgaddr_valid_o = valid_q;
    assign alloc_req_o       = req_q;
    assign busy_o            = (|pend_q) || (state_q != S_IDLE);

`ifdef MPM_PG_ALLOC_ARB_STATS_EN
    logic [31:0]         grant_q, nomem_q;
    logic [15:0]         maxw_q, wait_max;
    logic [N-1:0][15:0]  wait_q;

    always_comb begin
        wait_max = maxw_q;
        for (int i = 0; i < N; i++)
            if (wait_q[i] > wait_max) wait_max = wait_q[i];
    end

    always_ff @(posedge clk_core_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_q <= '0;
            nomem_q <= '0;
            maxw_q  <= '0;
            wait_q  <= '0;
        end else if (stats_clr_i) begin
            grant_q <= '0;
            nomem_q <= '0;
            maxw_q  <= '0;
            wait_q  <= '0;
        end else begin
            if (serve && grant_q != '1)    grant_q <= grant_q + 32'd1;
            if (nomem_ev && nomem_q != '1) nomem_q <= nomem_q + 32'd1;
            maxw_q <= wait_max;
            for (int i = 0; i < N; i++) begin
                if (!pend_q[i])           wait_q[i] <= '0;
                else if (wait_q[i] != '1) wait_q[i] <= wait_q[i] + 16'd1;
            end
        end
    end

    assign grant_cnt_o = grant_q;
    assign nomem_cnt_o = nomem_q;
    assign max_wait_o  = maxw_q;
`endif
endmodule
